// File: rtl/mux_sel_scanner.sv
// Sequencer for a 4:1 mux: steps sel through channels 0..3 with a programmable dwell,
// samples f on the last cycle of each dwell and publishes a 4-bit frame with a done pulse.
module mux_sel_scanner #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               f,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [3:0]         samp,
  output logic               done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StScan = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         shadow_q, shadow_d;
  logic [3:0]         samp_q, samp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    shadow_d = shadow_q;
    samp_d   = samp_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          sel_d   = 2'd0;
          cnt_d   = '0;
          dwell_d = dwell;
        end
      end
      StScan: begin
        if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (sel_q != 2'd3) begin
            shadow_d[sel_q] = f;
            sel_d           = sel_q + 2'd1;
          end else begin
            // Last channel goes straight into the frame; the shadow only holds 0..2.
            samp_d = {f, shadow_q};
            done_d = 1'b1;
            sel_d  = 2'd0;
            if (cont) begin
              dwell_d = dwell;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StScan);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= 2'd0;
      cnt_q    <= '0;
      dwell_q  <= '0;
      shadow_q <= 3'd0;
      samp_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      shadow_q <= shadow_d;
      samp_q   <= samp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign samp = samp_q;
  assign done = done_q;

endmodule
